// File: rtl/ahb_si_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_si_arbiter
//
// Round-robin grant arbiter for one AHB slave interface shared by
// CHANNEL_NUM masters. The grant (sel / hmaster) only moves at an
// arbitration point: the arbiter is IDLE and hready is high. Once the owner
// starts a fixed-length burst (BURST) or an undefined-length INCR burst
// (HOLD), the grant is frozen until that transfer finishes. After every
// return to IDLE there is one more IDLE cycle before the grant can move.
// When nobody requests, the grant parks on the last owner.
//
// Optional feature, controlled by the macro AHB_ARB_LOCK_EN:
//   defined   - the owner's hlock bit pulls the arbiter into HOLD, and the
//               grant stays there until the owner drops hlock.
//   undefined - hlock is ignored and HOLD is reached only through INCR.
//
// Parameters:
//   CHANNEL_NUM : number of requesting masters, 2..16 (default 7)
//
// Ports:
//   HCLK     in   clock, all state updates on its rising edge
//   HRESET   in   synchronous active-high reset
//   hreq     in   [CHANNEL_NUM]  bus request per master
//   hlock    in   [CHANNEL_NUM]  locked-transfer request per master
//   htrans   in   [2]            HTRANS of the granted master
//   hburst   in   [3]            HBURST of the granted master
//   hready   in                  slave HREADY, a beat completes when high
//   sel      out  [CHANNEL_NUM]  registered one-hot grant (payload mux select)
//   hmaster  out  [clog2(N)]     binary index of the granted master
//   arb_busy out                 high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module ahb_si_arbiter #(
  parameter int CHANNEL_NUM = 7
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [CHANNEL_NUM-1:0]         hreq,
  input  logic [CHANNEL_NUM-1:0]         hlock,
  input  logic [1:0]                     htrans,
  input  logic [2:0]                     hburst,
  input  logic                           hready,
  output logic [CHANNEL_NUM-1:0]         sel,
  output logic [$clog2(CHANNEL_NUM)-1:0] hmaster,
  output logic                           arb_busy
);

  localparam int HM_W = $clog2(CHANNEL_NUM);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [CHANNEL_NUM-1:0] sel_q, sel_d;
  logic [HM_W-1:0]        hmaster_q, hmaster_d;
  // Set while HOLD is owned through hlock rather than through an INCR burst;
  // the two kinds of HOLD are released by different signals.
  logic                   lock_hold_q, lock_hold_d;

  logic                   win_found;
  logic [HM_W-1:0]        win_idx;
  logic [4:0]             burst_beats_m1;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   hold_release;

  assign owner_req = hreq[hmaster_q];

`ifdef AHB_ARB_LOCK_EN
  assign owner_lock = hlock[hmaster_q];
`else
  // hlock has no effect in this build; fold it into a sink so it is visibly
  // consumed.
  logic unused_hlock;
  assign unused_hlock = ^hlock;
  assign owner_lock   = 1'b0;
`endif

  // Round-robin search starting just above the current owner. Channels above
  // hmaster are preferred over the wrapped-around ones, so the owner itself
  // only wins again when it is the sole requester. Each pass runs downward so
  // that the lowest matching channel is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_idx   = hmaster_q;
    for (int j = CHANNEL_NUM - 1; j >= 0; j--) begin
      if (hreq[j] && (j <= int'(hmaster_q))) begin
        win_found = 1'b1;
        win_idx   = HM_W'(j);
      end
    end
    for (int j = CHANNEL_NUM - 1; j >= 0; j--) begin
      if (hreq[j] && (j > int'(hmaster_q))) begin
        win_found = 1'b1;
        win_idx   = HM_W'(j);
      end
    end
  end

  // Beats remaining after the NONSEQ beat: 4/8/16-beat bursts load 3/7/15.
  // WRAPx and INCRx share a length, so only hburst[2:1] matters here.
  always_comb begin
    unique case (hburst[2:1])
      2'b01:   burst_beats_m1 = 5'd3;
      2'b10:   burst_beats_m1 = 5'd7;
      2'b11:   burst_beats_m1 = 5'd15;
      default: burst_beats_m1 = 5'd0;
    endcase
  end

  // A locked HOLD ends when the owner drops hlock; an INCR HOLD ends when the
  // owner drops its request.
  assign hold_release = lock_hold_q ? !owner_lock : !owner_req;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      sel_q       <= CHANNEL_NUM'(1);
      hmaster_q   <= '0;
      lock_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      hmaster_q   <= hmaster_d;
      lock_hold_q <= lock_hold_d;
    end
  end

  // Everything holds while hready is low. Arbitration only happens in IDLE,
  // and a cycle that returns to IDLE never arbitrates, which gives the one
  // cycle gap before a new grant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    hmaster_d   = hmaster_q;
    lock_hold_d = lock_hold_q;

    if (hready) begin
      unique case (state_q)
        ST_IDLE: begin
          if (owner_lock) begin
            state_d     = ST_HOLD;
            lock_hold_d = 1'b1;
          end else if ((htrans == TRANS_NONSEQ) && (hburst == BURST_INCR)) begin
            state_d     = ST_HOLD;
            lock_hold_d = 1'b0;
          end else if ((htrans == TRANS_NONSEQ) && (hburst != BURST_SINGLE)) begin
            state_d = ST_BURST;
            cnt_d   = burst_beats_m1;
          end else if (win_found) begin
            // SINGLE transfers and idle cycles both leave the grant free to
            // move. With no requests at all the grant stays parked.
            sel_d          = '0;
            sel_d[win_idx] = 1'b1;
            hmaster_d      = win_idx;
          end
        end

        ST_BURST: begin
          if (owner_lock) begin
            state_d     = ST_HOLD;
            lock_hold_d = 1'b1;
            cnt_d       = 5'd0;
          end else if ((cnt_q == 5'd0) || (htrans == TRANS_IDLE) ||
                       (htrans == TRANS_NONSEQ)) begin
            // Normal end of burst, or the master abandoned it early.
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
          end else if (htrans == TRANS_SEQ) begin
            cnt_d = cnt_q - 5'd1;
          end
          // BUSY beats leave the counter untouched.
        end

        ST_HOLD: begin
          if (hold_release) begin
            state_d     = ST_IDLE;
            lock_hold_d = 1'b0;
            cnt_d       = 5'd0;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          lock_hold_d = 1'b0;
          cnt_d       = 5'd0;
        end
      endcase
    end
  end

  assign sel      = sel_q;
  assign hmaster  = hmaster_q;
  assign arb_busy = (state_q != ST_IDLE);

  // The slave payload mux relies on a clean one-hot select that matches
  // hmaster on every cycle.
  a_sel_onehot: assert property (@(posedge HCLK) disable iff (HRESET)
                                 $onehot(sel_q));
  a_hmaster_match: assert property (@(posedge HCLK) disable iff (HRESET)
                                    sel_q[hmaster_q]);

endmodule

// File: tb/tb_ahb_si_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_si_arbiter
//
// Directed bench for ahb_si_arbiter (CHANNEL_NUM = 7). A table of
// {inputs, expected grant, expected busy} records is applied one cycle per
// record; the locked-burst scenario is written out by hand because its
// expectations depend on AHB_ARB_LOCK_EN.
// ---------------------------------------------------------------------------
module tb_ahb_si_arbiter;

  localparam int N = 7;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic         HCLK   = 1'b0;
  logic         HRESET = 1'b1;
  logic [N-1:0] hreq   = '0;
  logic [N-1:0] hlock  = '0;
  logic [1:0]   htrans = 2'd0;
  logic [2:0]   hburst = 3'd0;
  logic         hready = 1'b0;
  logic [N-1:0] sel;
  logic [2:0]   hmaster;
  logic         arb_busy;

  int tests    = 0;
  int failures = 0;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] lck;
    logic [1:0]   tr;
    logic [2:0]   hb;
    logic         rdy;
    int           exp_ch;
    logic         exp_busy;
  } vec_t;

  vec_t  vecs[$];
  string tags[$];
  int    hand_idx = 0;

  ahb_si_arbiter #(.CHANNEL_NUM(N)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .hreq     (hreq),
    .hlock    (hlock),
    .htrans   (htrans),
    .hburst   (hburst),
    .hready   (hready),
    .sel      (sel),
    .hmaster  (hmaster),
    .arb_busy (arb_busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic mk(output vec_t v, input logic rst, input logic [N-1:0] req,
                    input logic [N-1:0] lck, input logic [1:0] tr,
                    input logic [2:0] hb, input logic rdy, input int ch,
                    input logic busy);
    v.rst      = rst;
    v.req      = req;
    v.lck      = lck;
    v.tr       = tr;
    v.hb       = hb;
    v.rdy      = rdy;
    v.exp_ch   = ch;
    v.exp_busy = busy;
  endtask

  task automatic add(input string tag, input logic rst, input logic [N-1:0] req,
                     input logic [N-1:0] lck, input logic [1:0] tr,
                     input logic [2:0] hb, input logic rdy, input int ch,
                     input logic busy);
    vec_t v;
    mk(v, rst, req, lck, tr, hb, rdy, ch, busy);
    vecs.push_back(v);
    tags.push_back(tag);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge HCLK);
    HRESET = v.rst;
    hreq   = v.req;
    hlock  = v.lck;
    htrans = v.tr;
    hburst = v.hb;
    hready = v.rdy;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int idx);
    logic [N-1:0] es;
    logic [2:0]   em;
    es = N'(1) << v.exp_ch;
    em = 3'(v.exp_ch);
    tests++;
    if ((sel !== es) || (hmaster !== em) || (arb_busy !== v.exp_busy)) begin
      failures++;
      $display("[TB] FAIL %s #%0d: got sel=%b hmaster=%0d arb_busy=%b, want sel=%b hmaster=%0d arb_busy=%b",
               tag, idx, sel, hmaster, arb_busy, es, em, v.exp_busy);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int idx);
    applyStimulus(v);
    @(posedge HCLK);
    #1;
    checkOutput(v, tag, idx);
  endtask

  task automatic seq_step(input string tag, input logic [N-1:0] req,
                          input logic [N-1:0] lck, input logic [1:0] tr,
                          input logic [2:0] hb, input logic rdy, input int ch,
                          input logic busy);
    vec_t v;
    mk(v, 1'b0, req, lck, tr, hb, rdy, ch, busy);
    run_vec(v, tag, hand_idx);
    hand_idx++;
  endtask

  initial begin
    // Reset, then park on channel 0 with no requests
    add("reset", 1, 7'b0000000, '0, T_IDLE, B_SINGLE, 0, 0, 0);
    add("reset", 1, 7'b0000000, '0, T_IDLE, B_SINGLE, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      add("park", 0, 7'b0000000, '0, T_IDLE, B_SINGLE, 1, 0, 0);

    // Round robin over channels 1, 2, 4 with SINGLE transfers
    add("rr", 0, 7'b0010110, '0, T_NONSEQ, B_SINGLE, 1, 1, 0);
    add("rr", 0, 7'b0010110, '0, T_NONSEQ, B_SINGLE, 1, 2, 0);
    add("rr", 0, 7'b0010110, '0, T_NONSEQ, B_SINGLE, 1, 4, 0);
    add("rr", 0, 7'b0010110, '0, T_NONSEQ, B_SINGLE, 1, 1, 0);

    // Channel 3 INCR4 with wait states and a BUSY beat, everyone requesting
    add("incr4", 0, 7'b0001000, '0, T_IDLE,   B_SINGLE, 1, 3, 0);
    add("incr4", 0, 7'b1111111, '0, T_NONSEQ, B_INCR4,  1, 3, 1);
    add("incr4", 0, 7'b1111111, '0, T_SEQ,    B_INCR4,  0, 3, 1);
    add("incr4", 0, 7'b1111111, '0, T_SEQ,    B_INCR4,  1, 3, 1);
    add("incr4", 0, 7'b1111111, '0, T_BUSY,   B_INCR4,  1, 3, 1);
    add("incr4", 0, 7'b1111111, '0, T_SEQ,    B_INCR4,  0, 3, 1);
    add("incr4", 0, 7'b1111111, '0, T_SEQ,    B_INCR4,  1, 3, 1);
    add("incr4", 0, 7'b1111111, '0, T_SEQ,    B_INCR4,  0, 3, 1);
    add("incr4", 0, 7'b1111111, '0, T_SEQ,    B_INCR4,  1, 3, 1);
    add("incr4", 0, 7'b1111111, '0, T_IDLE,   B_INCR4,  1, 3, 0);
    add("incr4", 0, 7'b1111111, '0, T_IDLE,   B_SINGLE, 1, 4, 0);

    // Channel 2 INCR8 cut short by IDLE after three beats
    add("incr8", 0, 7'b0000100, '0, T_IDLE,   B_SINGLE, 1, 2, 0);
    add("incr8", 0, 7'b1000100, '0, T_NONSEQ, B_INCR8,  1, 2, 1);
    add("incr8", 0, 7'b1000100, '0, T_SEQ,    B_INCR8,  1, 2, 1);
    add("incr8", 0, 7'b1000100, '0, T_SEQ,    B_INCR8,  1, 2, 1);
    add("incr8", 0, 7'b1000100, '0, T_IDLE,   B_INCR8,  1, 2, 0);
    add("incr8", 0, 7'b1000100, '0, T_IDLE,   B_SINGLE, 1, 6, 0);

    // Channel 5 INCR for six beats while channel 6 waits
    add("incr", 0, 7'b0100000, '0, T_IDLE,   B_SINGLE, 1, 5, 0);
    add("incr", 0, 7'b1100000, '0, T_NONSEQ, B_INCR,   1, 5, 1);
    for (int i = 0; i < 5; i++)
      add("incr", 0, 7'b1100000, '0, T_SEQ, B_INCR, 1, 5, 1);
    add("incr", 0, 7'b1000000, '0, T_IDLE,   B_INCR,   0, 5, 1);
    add("incr", 0, 7'b1000000, '0, T_IDLE,   B_INCR,   1, 5, 0);
    add("incr", 0, 7'b1000000, '0, T_IDLE,   B_SINGLE, 1, 6, 0);

    // Reset in the middle of an INCR16 burst
    add("rstburst", 0, 7'b0001000, '0, T_IDLE,   B_SINGLE, 1, 3, 0);
    add("rstburst", 0, 7'b0001000, '0, T_NONSEQ, B_INCR16, 1, 3, 1);
    add("rstburst", 0, 7'b0001000, '0, T_SEQ,    B_INCR16, 1, 3, 1);
    add("rstburst", 1, 7'b1111111, '0, T_SEQ,    B_INCR16, 1, 0, 0);
    add("rstburst", 0, 7'b0000000, '0, T_IDLE,   B_SINGLE, 1, 0, 0);

    // Wait states in IDLE freeze arbitration
    add("wait", 0, 7'b0000010, '0, T_IDLE, B_SINGLE, 0, 0, 0);
    add("wait", 0, 7'b0000010, '0, T_IDLE, B_SINGLE, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], tags[i], i);

    // Channel 4 locked INCR4 bursts with channel 5 waiting
    seq_step("lock", 7'b0010000, 7'b0000000, T_IDLE,   B_SINGLE, 1, 4, 0);
    seq_step("lock", 7'b0110000, 7'b0010000, T_NONSEQ, B_INCR4,  1, 4, 1);
    for (int i = 0; i < 3; i++)
      seq_step("lock", 7'b0110000, 7'b0010000, T_SEQ, B_INCR4, 1, 4, 1);
`ifdef AHB_ARB_LOCK_EN
    seq_step("lock", 7'b0110000, 7'b0010000, T_IDLE,   B_INCR4,  1, 4, 1);
    seq_step("lock", 7'b0110000, 7'b0010000, T_NONSEQ, B_INCR4,  1, 4, 1);
    for (int i = 0; i < 3; i++)
      seq_step("lock", 7'b0110000, 7'b0010000, T_SEQ, B_INCR4, 1, 4, 1);
    seq_step("lock", 7'b0110000, 7'b0000000, T_IDLE,   B_SINGLE, 0, 4, 1);
    seq_step("lock", 7'b0110000, 7'b0000000, T_IDLE,   B_SINGLE, 1, 4, 0);
    seq_step("lock", 7'b0110000, 7'b0000000, T_IDLE,   B_SINGLE, 1, 5, 0);
`else
    seq_step("lock", 7'b0110000, 7'b0010000, T_IDLE,   B_INCR4,  1, 4, 0);
    seq_step("lock", 7'b0110000, 7'b0010000, T_IDLE,   B_SINGLE, 1, 5, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
